pipeline_hazard_ctrl: RTL

- Sequencing controller for the 3-stage pipeline (IF/ID, EX, WB) built around the instruction decoder and the register-file/ALU datapath.
- Tracks in-flight register writes in a scoreboard and stalls ID on read-after-write hazards.
- Resolves branches/jumps in EX from the decoder's BS/PS fields and the ALU zero flag, then squashes wrong-path instructions.
- Drives the stall, flush and PC-select controls consumed by the PC and the pipeline registers.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/hazard_scoreboard.sv | 59 +++++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: decoder BS/MD fields,
// PC-select codes and the controller FSM states.
package cpu_ctrl_pkg;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JMR  = 2'b10;
    localparam logic [1:0] BS_JMP  = 2'b11;

    localparam logic [1:0] MD_ALU  = 2'b00;
    localparam logic [1:0] MD_MEM  = 2'b01;
    localparam logic [1:0] MD_SLT  = 2'b10;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register-write tracker: a shift register of {valid, addr, is_load}
// (entry 0 = EX) with per-entry source-operand match vectors.
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              push_load,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DEPTH-1:0]  match_a,
    output logic [DEPTH-1:0]  match_b,
    output logic [DEPTH-1:0]  entry_load
);

    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  load_reg;
    logic [ADDR_W-1:0] addr_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_reg[gi] <= 1'b0;
                        load_reg[gi]  <= 1'b0;
                        addr_reg[gi]  <= '0;
                    end else begin
                        valid_reg[gi] <= push_valid;
                        load_reg[gi]  <= push_load;
                        addr_reg[gi]  <= push_addr;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_reg[gi] <= 1'b0;
                        load_reg[gi]  <= 1'b0;
                        addr_reg[gi]  <= '0;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        load_reg[gi]  <= load_reg[gi-1];
                        addr_reg[gi]  <= addr_reg[gi-1];
                    end
                end
            end

            // R0 is hardwired, so a pending write to it is never a real dependency.
            assign match_a[gi]    = valid_reg[gi] && (addr_reg[gi] == addr_a) && (addr_a != '0);
            assign match_b[gi]    = valid_reg[gi] && (addr_reg[gi] == addr_b) && (addr_b != '0);
            assign entry_load[gi] = valid_reg[gi] && load_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/PC-select controller for the 3-stage pipeline. Define FORWARDING_EN
// to replace EX-stage ALU hazards with operand forwarding instead of stalls.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int SB_DEPTH            = 2,
    parameter int FLUSH_CYCLES        = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    input  logic                           id_RW,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_DA,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_AA,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_BA,
    input  logic                           id_MA,
    input  logic                           id_MB,
    input  logic [1:0]                     id_MD,
    input  logic [1:0]                     id_BS,
    input  logic                           id_PS,
    input  logic                           ex_Z,
    output logic                           stall,
    output logic                           flush,
    output logic [1:0]                     pc_sel,
    output logic                           branch_taken,
    output logic                           fwd_a,
    output logic                           fwd_b
);

    localparam logic [1:0] FLUSH_EXTRA = 2'(FLUSH_CYCLES - 1);

    state_e     state_reg;
    logic [1:0] flush_cnt_reg;
    logic [1:0] ex_bs_reg;
    logic       ex_ps_reg;

    logic [SB_DEPTH-1:0] match_a;
    logic [SB_DEPTH-1:0] match_b;
    logic [SB_DEPTH-1:0] entry_load;

    logic       taken;
    logic [1:0] taken_sel;
    logic       need_a;
    logic       need_b;
    logic       push_valid;

    hazard_scoreboard #(
        .ADDR_W (REGISTER_ADDR_WIDTH),
        .DEPTH  (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_addr  (id_DA),
        .push_load  (id_MD == MD_MEM),
        .addr_a     (id_AA),
        .addr_b     (id_BA),
        .match_a    (match_a),
        .match_b    (match_b),
        .entry_load (entry_load)
    );

    always_comb begin
        taken     = 1'b0;
        taken_sel = PC_INC;
        if (state_reg == ST_RUN) begin
            case (ex_bs_reg)
                BS_COND: begin
                    taken     = ex_Z ^ ex_ps_reg;
                    taken_sel = (ex_Z ^ ex_ps_reg) ? PC_BRANCH : PC_INC;
                end
                BS_JMR: begin
                    taken     = 1'b1;
                    taken_sel = PC_REG;
                end
                BS_JMP: begin
                    taken     = 1'b1;
                    taken_sel = PC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign flush        = taken || (state_reg == ST_FLUSH);
    assign branch_taken = taken;
    assign pc_sel       = taken_sel;

`ifdef FORWARDING_EN
    // Only a non-load result sitting in EX can be bypassed; anything else waits.
    assign need_a = !id_MA && ((match_a[0] && entry_load[0]) || (|(match_a >> 1)));
    assign need_b = !id_MB && ((match_b[0] && entry_load[0]) || (|(match_b >> 1)));
    assign fwd_a  = id_valid && !flush && !stall && !id_MA && match_a[0] && !entry_load[0];
    assign fwd_b  = id_valid && !flush && !stall && !id_MB && match_b[0] && !entry_load[0];
`else
    logic unused_load;
    assign unused_load = ^entry_load;
    assign need_a = !id_MA && (|match_a);
    assign need_b = !id_MB && (|match_b);
    assign fwd_a  = 1'b0;
    assign fwd_b  = 1'b0;
`endif

    assign stall      = id_valid && !flush && (need_a || need_b);
    assign push_valid = id_valid && id_RW && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= 2'd0;
            ex_bs_reg     <= BS_NONE;
            ex_ps_reg     <= 1'b0;
        end else begin
            if (!stall && !flush) begin
                ex_bs_reg <= id_BS;
                ex_ps_reg <= id_PS;
            end else begin
                ex_bs_reg <= BS_NONE;
                ex_ps_reg <= 1'b0;
            end

            case (state_reg)
                ST_RUN: begin
                    // The taken cycle itself is the first flush cycle.
                    if (taken && (FLUSH_EXTRA != 2'd0)) begin
                        state_reg     <= ST_FLUSH;
                        flush_cnt_reg <= FLUSH_EXTRA;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_reg <= 2'd1) begin
                        state_reg     <= ST_RUN;
                        flush_cnt_reg <= 2'd0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 2'd1;
                    end
                end
                default: begin
                    state_reg     <= ST_RUN;
                    flush_cnt_reg <= 2'd0;
                end
            endcase
        end
    end

endmodule
